// File: rtl/layer_input_if.sv
// layer_input_if: sample stream in, packed frame and control strobes out
interface layer_input_if #(
    parameter int weightNo  = 10,
    parameter int dataWidth = 16
);
    logic                          in_valid;
    logic [dataWidth-1:0]          in_data;
    logic                          in_last;
    logic                          in_ready;
    logic                          layer_done;
    logic [weightNo*dataWidth-1:0] out;
    logic                          go_out_r;
    logic                          first;
    logic                          err;
    modport master (
        output in_valid, in_data, in_last, layer_done,
        input  in_ready, out, go_out_r, first, err
    );
    modport slave (
        input  in_valid, in_data, in_last, layer_done,
        output in_ready, out, go_out_r, first, err
    );
endinterface

// File: rtl/layer_input_packer.sv
// layer_input_packer: packs weightNo stream samples into a parallel frame and strobes it to the layer
module layer_input_packer #(
    parameter int weightNo  = 10,
    parameter int dataWidth = 16,
    parameter bit WAIT_DONE = 1'b1
) (
    input logic        clk,
    input logic        rst,
    layer_input_if.slave bus
);
    localparam int IW = $clog2(weightNo);
    localparam logic [IW-1:0] LAST = IW'(weightNo - 1);
    typedef enum logic [1:0] {FILL, FIRE, WAIT} state_t;
    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [weightNo*dataWidth-1:0] out_q, out_d;
    logic                          go_q, go_d;
    logic                          first_q, first_d;
    logic                          err_q, err_d;
    logic                          accept;
    assign bus.in_ready = (state_q == FILL);
    assign bus.out      = out_q;
    assign bus.go_out_r = go_q;
    assign bus.first    = first_q;
    assign bus.err      = err_q;
    assign accept       = bus.in_valid && (state_q == FILL);
    // Next state: lane writes and frame counting in FILL, one-cycle strobe in FIRE, layer handshake in WAIT
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        go_d    = 1'b0;
        first_d = first_q;
        err_d   = err_q;
        case (state_q)
            FILL: if (accept) begin
                for (int i = 0; i < weightNo; i++)
                    if (idx_q == IW'(i)) out_d[i*dataWidth +: dataWidth] = bus.in_data;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = FIRE;
                    go_d    = 1'b1;
                end else if (bus.in_last) begin
                    idx_d = '0;
                    err_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            FIRE: begin
                state_d = WAIT_DONE ? WAIT : FILL;
                first_d = WAIT_DONE ? first_q : 1'b0;
            end
            WAIT: if (bus.layer_done) begin
                state_d = FILL;
                first_d = 1'b0;
            end
            default: state_d = FILL;
        endcase
    end
    // State and output registers; reset drops any partial frame immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            out_q   <= '0;
            go_q    <= 1'b0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            go_q    <= go_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_layer_input_packer.sv
// tb_layer_input_packer: randomized frames checked against a lane-array model of the packer
module tb_layer_input_packer;
    localparam int W = 10;
    localparam int D = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   go_cnt = 0;
    logic [D-1:0] fd [W];
    logic [D-1:0] m_lane [W];
    int   m_idx = 0;
    int   m_fires = 0;
    bit   m_err = 1'b0;
    bit   m_first = 1'b1;
    layer_input_if #(.weightNo(W), .dataWidth(D)) bus ();
    layer_input_packer #(.weightNo(W), .dataWidth(D), .WAIT_DONE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.go_out_r === 1'b1) go_cnt <= go_cnt + 1;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
    function automatic logic [W*D-1:0] exp_out();
        logic [W*D-1:0] r;
        for (int i = 0; i < W; i++) r[i*D +: D] = m_lane[i];
        return r;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < W; i++) m_lane[i] = '0;
        m_idx = 0;
        m_err = 1'b0;
        m_first = 1'b1;
    endtask
    task automatic model_accept(input logic [D-1:0] d, input bit l);
        m_lane[m_idx] = d;
        if (m_idx == W - 1) begin
            m_idx = 0;
            m_fires++;
        end else if (l) begin
            m_idx = 0;
            m_err = 1'b1;
        end else begin
            m_idx++;
        end
    endtask
    task automatic beat(input logic [D-1:0] d, input bit l);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            $display("FAIL beat_ready: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        model_accept(d, l);
    endtask
    task automatic send_range(input int lo, input int hi, input int last_pos, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            beat(fd[i], i == last_pos);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask
    task automatic check_fire(input string tag);
        total++; if (bus.go_out_r !== 1'b1) $display("FAIL %s_go: go_out_r=%b, required 1", tag, bus.go_out_r); else passed++;
        total++; if (bus.out !== exp_out()) $display("FAIL %s_out: out=%h, required %h", tag, bus.out, exp_out()); else passed++;
        total++; if (bus.first !== m_first) $display("FAIL %s_first: first=%b, required %b", tag, bus.first, m_first); else passed++;
        total++; if (bus.err !== m_err) $display("FAIL %s_err: err=%b, required %b", tag, bus.err, m_err); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL %s_ready: in_ready=%b, required 0", tag, bus.in_ready); else passed++;
        @(negedge clk);
        total++; if (bus.go_out_r !== 1'b0) $display("FAIL %s_go_width: go_out_r=%b, required 0", tag, bus.go_out_r); else passed++;
        total++; if (go_cnt !== m_fires) $display("FAIL %s_go_count: pulses=%0d, required %0d", tag, go_cnt, m_fires); else passed++;
    endtask
    task automatic release_wait(input string tag);
        bus.layer_done = 1'b1;
        @(negedge clk);
        bus.layer_done = 1'b0;
        m_first = 1'b0;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL %s_release_ready: in_ready=%b, required 1", tag, bus.in_ready); else passed++;
        total++; if (bus.first !== 1'b0) $display("FAIL %s_release_first: first=%b, required 0", tag, bus.first); else passed++;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.out !== exp_out()) $display("FAIL reset_out: out=%h, required %h", bus.out, exp_out()); else passed++;
        total++; if (bus.go_out_r !== 1'b0) $display("FAIL reset_go: go_out_r=%b, required 0", bus.go_out_r); else passed++;
        total++; if (bus.first !== 1'b1) $display("FAIL reset_first: first=%b, required 1", bus.first); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL reset_err: err=%b, required 0", bus.err); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, required 1", bus.in_ready); else passed++;
    endtask
    task automatic test_basic_frame();
        for (int i = 0; i < W; i++) fd[i] = D'(i + 1);
        send_range(0, W - 1, W - 1, 1'b0);
        check_fire("t1");
    endtask
    task automatic test_wait_hold();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++; if (bus.in_ready !== 1'b0 || bus.out !== exp_out()) $display("FAIL t2_hold: in_ready=%b out=%h, required 0 and %h", bus.in_ready, bus.out, exp_out()); else passed++;
        end
        release_wait("t2");
        for (int i = 0; i < W; i++) fd[i] = 16'hEEEE;
        send_range(0, W - 1, W - 1, 1'b0);
        check_fire("t2");
        release_wait("t2b");
    endtask
    task automatic test_early_last();
        int g0;
        for (int i = 0; i < W; i++) fd[i] = D'($urandom);
        g0 = m_fires;
        send_range(0, 3, 3, 1'b0);
        repeat (3) @(negedge clk);
        total++; if (bus.err !== 1'b1) $display("FAIL t3_err: err=%b, required 1", bus.err); else passed++;
        total++; if (go_cnt !== g0) $display("FAIL t3_no_go: pulses=%0d, required %0d", go_cnt, g0); else passed++;
        total++; if (bus.out !== exp_out()) $display("FAIL t3_partial: out=%h, required %h", bus.out, exp_out()); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL t3_ready: in_ready=%b, required 1", bus.in_ready); else passed++;
        for (int i = 0; i < W; i++) fd[i] = D'($urandom);
        send_range(0, W - 1, W - 1, 1'b0);
        total++; if (bus.out[D-1:0] !== fd[0]) $display("FAIL t3_lane0: lane0=%h, required %h", bus.out[D-1:0], fd[0]); else passed++;
        check_fire("t3");
        release_wait("t3");
    endtask
    task automatic test_gaps();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W; i++) fd[i] = D'($urandom);
            send_range(0, W - 1, (f == 1) ? -1 : W - 1, 1'b1);
            check_fire("t4");
            release_wait("t4");
        end
    endtask
    task automatic test_mid_reset();
        for (int i = 0; i < W; i++) fd[i] = 16'hEFEF;
        send_range(0, 4, -1, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (bus.out !== '0) $display("FAIL t5_out: out=%h, required 0", bus.out); else passed++;
        total++; if (bus.go_out_r !== 1'b0 || bus.first !== 1'b1 || bus.err !== 1'b0) $display("FAIL t5_flags: go=%b first=%b err=%b, required 0 1 0", bus.go_out_r, bus.first, bus.err); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < W; i++) fd[i] = D'($urandom);
        send_range(0, W - 1, W - 1, 1'b0);
        check_fire("t5");
        release_wait("t5");
    endtask
    task automatic test_done_ignored();
        for (int i = 0; i < W; i++) fd[i] = D'($urandom);
        send_range(0, 4, -1, 1'b0);
        bus.layer_done = 1'b1;
        @(negedge clk);
        bus.layer_done = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || bus.first !== m_first) $display("FAIL t6_fill_done: in_ready=%b first=%b, required 1 %b", bus.in_ready, bus.first, m_first); else passed++;
        send_range(5, W - 1, W - 1, 1'b0);
        bus.layer_done = 1'b1;
        check_fire("t6");
        bus.layer_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (bus.in_ready !== 1'b0) $display("FAIL t6_still_wait: in_ready=%b, required 0", bus.in_ready); else passed++;
        end
        release_wait("t6");
    endtask
    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.layer_done = 1'b0;
        test_reset();
        test_basic_frame();
        test_wait_hold();
        test_early_last();
        test_gaps();
        test_mid_reset();
        test_done_ignored();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
